ad_pack_frame_ctrl: RTL and testbench
=====================================

Name: ad_pack_frame_ctrl

Overview:
- Frame sequencer for the ad_pack I_W-to-O_W unit width converter.
- Accepts framed input beats with a valid/ready/last handshake and drives the packer's idata/ivalid.
- At end of frame, injects pad beats until the packer's residual fill returns to zero, so every frame starts on an output-word boundary.
- Tags packer output words so the downstream side gets a word-aligned m_last, and all-pad words are suppressed.

Parameters:
- I_W, 4, input beat width in units.
- O_W, 6, packer output width in units; O_W > I_W.
- UNIT_W, 8, unit width in bits.
- PAD_VALUE, 8'h00, UNIT_W-bit value replicated into every unit of a pad beat.
- TAG_DEPTH, 4, depth of the in-flight output-word tag FIFO; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  I_W*UNIT_W  input beat; unit 0 in the LSBs.
- s_last  in  1  final beat of frame.
- pk_idata  out  I_W*UNIT_W  to packer idata.
- pk_ivalid  out  1  to packer ivalid.
- pk_ovalid  in  1  from packer ovalid.
- m_valid  out  1  packer odata is valid and forwarded (pk_ovalid & ~drop tag).
- m_last  out  1  qualifies m_valid: word carries the frame's last data unit.
- frame_count  out  16  frames completed (m_valid & m_last), wraps at 2^16.
- err_underflow  out  1  sticky: pk_ovalid seen with tag FIFO empty.

Behaviour:
- Reset (resetn low at posedge clk):
  - state=DATA, fill=0, tag FIFO emptied, pk_ivalid=0, pk_idata=0, s_ready=0 for that cycle.
  - frame_count=0, err_underflow=0, m_valid=0, m_last=0.
  - Reset mid-frame discards all state. The integrator must reset ad_pack (active-high) with ~resetn in the same cycle.
- fill: registered 0..O_W-1, units held in the packer.
  - Each push (pk_ivalid=1): sum = fill+I_W. If sum >= O_W the push completes a word and fill <= sum-O_W; otherwise fill <= sum.
  - Adder width clog2(O_W+I_W)+1.
- Completing push: writes one 2-bit tag {drop,last} into the FIFO in the push cycle.
  - Non-completing pushes write no tag.
- pk_idata/pk_ivalid are registered: 1-cycle latency from handshake or pad decision.
- State DATA:
  - s_ready = ~full_guard, where full_guard = tag count == TAG_DEPTH and the beat would complete a word.
  - Beat accepted: push s_data.
  - Accepted with s_last: compute fill_after.
    - fill_after==0: push tag last=1 on this (completing) beat; stay DATA.
    - Otherwise: -> PAD; an armed flag marks that the next completing push carries last=1.
- State PAD:
  - s_ready=0. Each cycle with FIFO space, push a pad beat (all units = PAD_VALUE).
  - First completing push while armed: tag {0,1}, armed cleared.
  - Subsequent completing pushes: tag {1,0} (all-pad word, dropped).
  - Exit to DATA on the cycle the push makes fill==0.
  - Guaranteed to terminate because fill is always a multiple of gcd(I_W,O_W).
- No backpressure from the packer side. Pad beats and data beats stall only on tag FIFO full.
- Output side, on pk_ovalid:
  - Pop the head tag. m_valid = ~drop, m_last = last & ~drop, combinational from the FIFO head.
  - If the FIFO is empty: m_valid=0 and err_underflow set.
- Simultaneous push and pop in one cycle: count unchanged, no data loss.
- Tag count range 0..TAG_DEPTH. An attempted push while full is impossible by design.

Test Plan:
- I_W=4, O_W=6. Frame of 3 beats of incrementing bytes 0..11, last on beat 3 -> no pad beats; 2 m_valid words (bytes 0..5, 6..11); m_last on word 2 only; frame_count=1.
- Frame of 1 beat (bytes 0..3) -> 2 pad beats. One m_valid word {PAD,PAD,3,2,1,0} with m_last=1. The all-pad second word has pk_ovalid=1 and m_valid=0. fill=0 afterwards.
- Frame of 2 beats (0..7) -> first word 0..5 with m_last=0; 1 pad beat; word {PAD,PAD,PAD,PAD,7,6} with m_last=1; state back in DATA.
- 200 random frames of 1..9 beats, s_valid toggling randomly at 50% -> per frame, output bytes equal input bytes in order; exactly one m_last per frame; frame_count=200; err_underflow=0.
- Freeze pk_ovalid (packer model stalls output) until the tag FIFO holds 4 entries -> s_ready drops only on word-completing beats; once released, no word lost.
- Assert resetn low mid-frame (after 1 beat) -> next cycle fill=0, FIFO empty, frame_count=0. The following 3-beat frame produces 2 correct words with m_last on word 2.

Source files
------------

// File: rtl/ad_pack_frame_ctrl.sv
// ad_pack_frame_ctrl: frame sequencer in front of the ad_pack width converter.
// Pads each frame out to an output-word boundary and tags packer words.
module ad_pack_frame_ctrl #(
  parameter int I_W = 4,
  parameter int O_W = 6,
  parameter int UNIT_W = 8,
  parameter logic [UNIT_W-1:0] PAD_VALUE = 8'h00,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [I_W*UNIT_W-1:0] s_data,
  input  logic                  s_last,
  output logic [I_W*UNIT_W-1:0] pk_idata,
  output logic                  pk_ivalid,
  input  logic                  pk_ovalid,
  output logic                  m_valid,
  output logic                  m_last,
  output logic [15:0]           frame_count,
  output logic                  err_underflow
);
  localparam int FW = $clog2(O_W + I_W) + 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {DATA, PAD} state_t;

  state_t state, state_nxt;
  logic armed, armed_nxt;
  logic [FW-1:0] fill, sum, fill_after;
  logic completes, full_guard;
  logic push, push_pad, tag_drop, tag_last;
  logic tag_push, pop, empty;
  logic [1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0] head;

  assign sum = fill + FW'(I_W);
  assign completes = sum >= FW'(O_W);
  assign fill_after = completes ? sum - FW'(O_W) : sum;
  assign full_guard = (count == CW'(TAG_DEPTH)) && completes;
  assign tag_push = push && completes;
  assign empty = (count == '0);
  assign head = tag_mem[rd_ptr];
  assign pop = resetn && pk_ovalid && !empty;
  assign m_valid = pop && !head[1];
  assign m_last = pop && !head[1] && head[0];

  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    s_ready = 1'b0;
    push = 1'b0;
    push_pad = 1'b0;
    tag_drop = 1'b0;
    tag_last = 1'b0;
    unique case (state)
      DATA: begin
        s_ready = resetn && !full_guard;
        if (s_valid && s_ready) begin
          push = 1'b1;
          if (s_last) begin
            if (fill_after == '0) begin
              tag_last = 1'b1;
            end else begin
              state_nxt = PAD;
              armed_nxt = 1'b1;
            end
          end
        end
      end
      PAD: begin
        if (!full_guard) begin
          push = 1'b1;
          push_pad = 1'b1;
          // first word closed after the data carries last; later ones are pure pad
          if (completes) begin
            tag_last = armed;
            tag_drop = !armed;
            armed_nxt = 1'b0;
          end
          if (fill_after == '0) state_nxt = DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DATA;
      armed <= 1'b0;
      fill <= '0;
      pk_ivalid <= 1'b0;
      pk_idata <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      frame_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= armed_nxt;
      pk_ivalid <= push;
      if (push) begin
        fill <= fill_after;
        pk_idata <= push_pad ? {I_W{PAD_VALUE}} : s_data;
      end
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(tag_push) - CW'(pop);
      if (m_valid && m_last) frame_count <= frame_count + 16'd1;
      if (pk_ovalid && empty) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr] <= {tag_drop, tag_last};
  end

endmodule

// File: tb/tb_ad_pack_frame_ctrl.sv
// tb_ad_pack_frame_ctrl: bench with a packer model and a unit-stream
// reference: output words must equal frame bytes, padded per frame.
module tb_ad_pack_frame_ctrl;
  localparam int I_W = 4;
  localparam int O_W = 6;
  localparam int UNIT_W = 8;
  localparam int TAG_DEPTH = 4;
  localparam int DW = I_W * UNIT_W;
  localparam int OWW = O_W * UNIT_W;
  localparam logic [7:0] PADV = 8'h00;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic [DW-1:0] pk_idata;
  logic pk_ivalid;
  logic pk_ovalid = 1'b0;
  logic m_valid, m_last;
  logic [15:0] frame_count;
  logic err_underflow;

  always #5 clk = ~clk;

  ad_pack_frame_ctrl #(
    .I_W(I_W), .O_W(O_W), .UNIT_W(UNIT_W),
    .PAD_VALUE(PADV), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .pk_idata(pk_idata), .pk_ivalid(pk_ivalid),
    .pk_ovalid(pk_ovalid),
    .m_valid(m_valid), .m_last(m_last),
    .frame_count(frame_count),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic [7:0] val;
    bit eof;
  } xu_t;

  typedef struct {
    int beats;
    int pads;
    int words;
    int drops;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [7:0] unitq[$];
  logic [OWW-1:0] outq[$];
  xu_t expq[$];
  bit freeze = 0;
  bit chk_stall = 0;
  bit force_ov = 0;
  int stall_k = -1;
  int n_push, n_words, n_drops, n_last;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_push = 0;
    n_words = 0;
    n_drops = 0;
    n_last = 0;
  endtask

  // packer model plus output checker
  always @(negedge clk) begin
    logic [OWW-1:0] w, ew;
    bit el;
    xu_t u;
    if (!resetn) begin
      pk_ovalid = 1'b0;
    end else begin
      pk_ovalid = force_ov || (!freeze && outq.size() > 0);
      if (pk_ivalid) begin
        n_push++;
        for (int i = 0; i < I_W; i++)
          unitq.push_back(pk_idata[i*UNIT_W +: UNIT_W]);
      end
      while (unitq.size() >= O_W) begin
        w = '0;
        for (int i = 0; i < O_W; i++)
          w[i*UNIT_W +: UNIT_W] = unitq.pop_front();
        outq.push_back(w);
      end
      #1;
      if (force_ov) begin
        check("underflow_mvalid", m_valid, 0);
      end else if (pk_ovalid) begin
        w = outq.pop_front();
        if (m_valid) begin
          n_words++;
          ew = '0;
          el = 0;
          for (int i = 0; i < O_W; i++) begin
            if (!el && expq.size() > 0) begin
              u = expq.pop_front();
              ew[i*UNIT_W +: UNIT_W] = u.val;
              el = u.eof;
            end else begin
              ew[i*UNIT_W +: UNIT_W] = PADV;
            end
          end
          check("word_data", w, ew);
          check("word_last", m_last, el);
          if (m_last) n_last++;
        end else begin
          n_drops++;
        end
      end else begin
        check("mvalid_idle", m_valid, 0);
      end
    end
  end

  task automatic send_frame(input int nb, input bit rnd,
                            input int base, input bit mark_last);
    logic [DW-1:0] d;
    int stall;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < I_W; i++)
        d[i*UNIT_W +: UNIT_W] =
          rnd ? 8'($urandom) : 8'(base + k * I_W + i);
      stall = 0;
      forever begin
        @(negedge clk);
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data = d;
        s_last = mark_last && (k == nb - 1);
        #1;
        if (s_valid && s_ready) break;
        if (s_valid && chk_stall) begin
          check("stall_on_completing",
                ((k + 1) * I_W) / O_W - (k * I_W) / O_W, 1);
          if (freeze)
            check("stall_fifo_full", (k * I_W) / O_W, TAG_DEPTH);
        end
        stall++;
        if (freeze && stall >= 5) begin
          stall_k = k;
          freeze = 0;
        end
        if (stall > 400) begin
          total++;
          bad++;
          $display("FAIL beat_timeout: beat %0d waited %0d cycles, want < 400",
                   k, stall);
          break;
        end
      end
      for (int i = 0; i < I_W; i++)
        expq.push_back('{val: d[i*UNIT_W +: UNIT_W],
                         eof: (mark_last && k == nb - 1 && i == I_W - 1)});
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int q;
    q = 0;
    for (int c = 0; c < 1000 && q < 4; c++) begin
      @(negedge clk);
      #2;
      if (!pk_ivalid && !pk_ovalid && outq.size() == 0 && unitq.size() == 0)
        q++;
      else
        q = 0;
    end
    check("idle_reached", (q >= 4) ? 1 : 0, 1);
  endtask

  initial begin
    vec_t vt[6];
    logic [15:0] fc0;
    vt = '{'{3, 0, 2, 0}, '{1, 2, 1, 1}, '{2, 1, 2, 0},
           '{4, 2, 3, 1}, '{5, 1, 4, 0}, '{6, 0, 4, 0}};

    repeat (3) @(negedge clk);
    #2;
    check("rst_pk_ivalid", pk_ivalid, 0);
    check("rst_pk_idata", pk_idata, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err", err_underflow, 0);
    resetn = 1'b1;
    @(negedge clk);
    #2;
    check("ready_after_reset", s_ready, 1);

    foreach (vt[i]) begin
      clr_cnt();
      fc0 = frame_count;
      send_frame(vt[i].beats, 0, 0, 1);
      wait_idle();
      check("pad_beats", n_push - vt[i].beats, vt[i].pads);
      check("data_words", n_words, vt[i].words);
      check("drop_words", n_drops, vt[i].drops);
      check("last_count", n_last, 1);
      check("frame_count", frame_count, 16'(fc0 + 16'd1));
      check("exp_drained", expq.size(), 0);
    end

    clr_cnt();
    freeze = 1;
    chk_stall = 1;
    send_frame(9, 0, 8'h40, 1);
    wait_idle();
    chk_stall = 0;
    freeze = 0;
    check("freeze_stall_beat", stall_k, 7);
    check("freeze_words", n_words, 6);
    check("freeze_drops", n_drops, 0);
    check("freeze_last", n_last, 1);
    check("freeze_drained", expq.size(), 0);

    clr_cnt();
    fc0 = frame_count;
    repeat (200) send_frame($urandom_range(1, 9), 1, 0, 1);
    wait_idle();
    check("rand_frame_count", frame_count, 16'(fc0 + 16'd200));
    check("rand_last_count", n_last, 200);
    check("rand_err", err_underflow, 0);
    check("rand_drained", expq.size(), 0);

    #1;
    force_ov = 1;
    @(negedge clk);
    #3;
    force_ov = 0;
    @(negedge clk);
    #2;
    check("underflow_sticky", err_underflow, 1);

    clr_cnt();
    send_frame(1, 0, 8'h20, 0);
    resetn = 1'b0;
    @(negedge clk);
    #2;
    unitq.delete();
    outq.delete();
    expq.delete();
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_err", err_underflow, 0);
    check("mid_rst_pk_ivalid", pk_ivalid, 0);
    check("mid_rst_s_ready", s_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #2;
    check("ready_after_mid_rst", s_ready, 1);
    clr_cnt();
    send_frame(3, 0, 8'h80, 1);
    wait_idle();
    check("post_rst_pushes", n_push, 3);
    check("post_rst_words", n_words, 2);
    check("post_rst_last", n_last, 1);
    check("post_rst_frame_count", frame_count, 1);
    check("post_rst_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
